// File: rtl/io_bus_arbiter.sv
// io_bus_arbiter
// Two-master round-robin transaction controller for the peripheral I/O slot bus.
// Master 0 is the CPU memory stage, master 1 a secondary requester (debug/DMA).
// A granted transaction drives one registered read or write strobe set onto the
// slot bus and waits for bus_ready. If bus_ready does not arrive within TIMEOUT
// cycles, the transaction is aborted. Completion is reported with a one-cycle
// ack, plus err on a timeout.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   mN_req/we/addr/wdata     master N request and payload (held until ack)
//   mN_rdata                 master N read data, holds until its next completion
//   mN_ack, mN_err           master N one-cycle completion / timeout flags
//   bus_read, bus_write      strobes to the slots (at most one high)
//   bus_addr, bus_wdata      latched address / write data (0 when idle)
//   bus_rdata, bus_ready     slot read data and completion

`ifndef IO_ADDR_WIDTH
`define IO_ADDR_WIDTH 32
`endif
`ifndef IO_DATA_WIDTH
`define IO_DATA_WIDTH 32
`endif

module io_bus_arbiter #(
  parameter int ADDR_WIDTH = `IO_ADDR_WIDTH,
  parameter int DATA_WIDTH = `IO_DATA_WIDTH,
  parameter int TIMEOUT    = 16,
  parameter int CNT_WIDTH  = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  m0_req,
  input  logic                  m0_we,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  output logic [DATA_WIDTH-1:0] m0_rdata,
  output logic                  m0_ack,
  output logic                  m0_err,
  input  logic                  m1_req,
  input  logic                  m1_we,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  output logic [DATA_WIDTH-1:0] m1_rdata,
  output logic                  m1_ack,
  output logic                  m1_err,
  output logic                  bus_read,
  output logic                  bus_write,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic [DATA_WIDTH-1:0] bus_wdata,
  input  logic [DATA_WIDTH-1:0] bus_rdata,
  input  logic                  bus_ready
);

  typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_DONE} state_t;

  // Per-master views of the request inputs so the grant can index them.
  logic [1:0]            req_in;
  logic [1:0]            we_in;
  logic [ADDR_WIDTH-1:0] addr_in  [2];
  logic [DATA_WIDTH-1:0] wdata_in [2];

  assign req_in      = {m1_req, m0_req};
  assign we_in       = {m1_we, m0_we};
  assign addr_in[0]  = m0_addr;
  assign addr_in[1]  = m1_addr;
  assign wdata_in[0] = m0_wdata;
  assign wdata_in[1] = m1_wdata;

  state_t                           state_q, state_d;
  logic                             last_q, last_d;     // last master granted
  logic                             gnt_q, gnt_d;       // master owning the access
  logic                             we_q, we_d;
  logic [CNT_WIDTH-1:0]             cnt_q, cnt_d;
  logic                             bus_read_q, bus_read_d;
  logic                             bus_write_q, bus_write_d;
  logic [ADDR_WIDTH-1:0]            bus_addr_q, bus_addr_d;
  logic [DATA_WIDTH-1:0]            bus_wdata_q, bus_wdata_d;
  logic [1:0][DATA_WIDTH-1:0]       rdata_q, rdata_d;
  logic [1:0]                       ack_q, ack_d;
  logic [1:0]                       err_q, err_d;

  logic sel;
  logic finish;
  logic timed_out;

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    gnt_d       = gnt_q;
    we_d        = we_q;
    cnt_d       = cnt_q;
    bus_read_d  = bus_read_q;
    bus_write_d = bus_write_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    rdata_d     = rdata_q;
    ack_d       = '0;
    err_d       = '0;
    sel         = 1'b0;
    finish      = 1'b0;
    timed_out   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (|req_in) begin
          // On a tie the master that did not go last wins; otherwise the sole requester.
          sel         = (&req_in) ? ~last_q : req_in[1];
          gnt_d       = sel;
          last_d      = sel;
          we_d        = we_in[sel];
          cnt_d       = '0;
          bus_read_d  = ~we_in[sel];
          bus_write_d = we_in[sel];
          bus_addr_d  = addr_in[sel];
          bus_wdata_d = we_in[sel] ? wdata_in[sel] : '0;
          state_d     = ST_ACCESS;
        end
      end

      ST_ACCESS: begin
        if (bus_ready) begin
          finish = 1'b1;
        end else if (cnt_q == CNT_WIDTH'(TIMEOUT - 1)) begin
          // This was the TIMEOUT-th strobe cycle without a response.
          finish    = 1'b1;
          timed_out = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
        end

        if (finish) begin
          state_d        = ST_DONE;
          bus_read_d     = 1'b0;
          bus_write_d    = 1'b0;
          bus_addr_d     = '0;
          bus_wdata_d    = '0;
          ack_d[gnt_q]   = 1'b1;
          err_d[gnt_q]   = timed_out;
          if (!we_q) begin
            rdata_d[gnt_q] = timed_out ? '1 : bus_rdata;
          end
        end
      end

      ST_DONE: begin
        // Requests are not sampled here; a held req becomes a new transaction in IDLE.
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      last_q      <= 1'b1;     // master 0 wins the first tie
      gnt_q       <= 1'b0;
      we_q        <= 1'b0;
      cnt_q       <= '0;
      bus_read_q  <= 1'b0;
      bus_write_q <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      rdata_q     <= '0;
      ack_q       <= '0;
      err_q       <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      gnt_q       <= gnt_d;
      we_q        <= we_d;
      cnt_q       <= cnt_d;
      bus_read_q  <= bus_read_d;
      bus_write_q <= bus_write_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      rdata_q     <= rdata_d;
      ack_q       <= ack_d;
      err_q       <= err_d;
    end
  end

  assign bus_read  = bus_read_q;
  assign bus_write = bus_write_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;
  assign m0_rdata  = rdata_q[0];
  assign m1_rdata  = rdata_q[1];
  assign m0_ack    = ack_q[0];
  assign m1_ack    = ack_q[1];
  assign m0_err    = err_q[0];
  assign m1_err    = err_q[1];

endmodule

// File: tb/tb_io_bus_arbiter.sv
module tb_io_bus_arbiter;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req, we;
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic [31:0] m0_rdata, m1_rdata;
  logic        m0_ack, m1_ack, m0_err, m1_err;
  logic        bus_read, bus_write;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic        bus_ready;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  io_bus_arbiter #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(TO), .CNT_WIDTH(5)
  ) dut (
    .clk(clk), .rst(rst),
    .m0_req(req[0]), .m0_we(we[0]), .m0_addr(addr[0]), .m0_wdata(wdata[0]),
    .m0_rdata(m0_rdata), .m0_ack(m0_ack), .m0_err(m0_err),
    .m1_req(req[1]), .m1_we(we[1]), .m1_addr(addr[1]), .m1_wdata(wdata[1]),
    .m1_rdata(m1_rdata), .m1_ack(m1_ack), .m1_err(m1_err),
    .bus_read(bus_read), .bus_write(bus_write), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ready(bus_ready)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [31:0] rd_of(input int m);
    return (m == 1) ? m1_rdata : m0_rdata;
  endfunction

  function automatic logic [1:0] onehot(input int m);
    return (m == 1) ? 2'b10 : 2'b01;
  endfunction

  task automatic do_reset();
    rst = 1'b1; req = '0; we = '0;
    addr[0] = '0; addr[1] = '0; wdata[0] = '0; wdata[1] = '0;
    bus_ready = 1'b0; bus_rdata = '0;
    step(); step();
    rst = 1'b0;
  endtask

  typedef struct {
    int          m;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;      // slot response
    int          delay;      // ACCESS index at which ready is given (>=TO: never)
    int          exp_strobes;
    logic        exp_err;
    logic [31:0] exp_rdata;
    int          exp_lat;    // cycles from req to ack
  } vec_t;

  vec_t vecs [6];

  task automatic run_vec(input vec_t v);
    int cyc = 0;
    int strobes = 0;
    bit got = 0;
    req[v.m] = 1'b1; we[v.m] = v.we; addr[v.m] = v.addr; wdata[v.m] = v.wdata;
    while (!got && cyc < 40) begin
      step();
      cyc++;
      if (bus_read || bus_write) begin
        chk("vec_addr", bus_addr, v.addr);
        chk("vec_wdata", bus_wdata, v.we ? v.wdata : 32'h0);
        chk("vec_rd_strobe", bus_read, !v.we);
        if (strobes == v.delay) begin bus_ready = 1'b1; bus_rdata = v.rdata; end
        else begin bus_ready = 1'b0; bus_rdata = 32'h0BADF00D; end
        strobes++;
      end else begin
        bus_ready = 1'b0;
      end
      if (m0_ack || m1_ack) got = 1;
    end
    if (!got) begin
      n_checks++; n_fail++;
      $display("FAIL vec_ack_timeout: got no ack, expected ack within 40 cycles");
    end
    chk("vec_latency", cyc, v.exp_lat);
    chk("vec_strobes", strobes, v.exp_strobes);
    chk("vec_ack", {m1_ack, m0_ack}, onehot(v.m));
    chk("vec_err", {m1_err, m0_err}, v.exp_err ? onehot(v.m) : 2'b00);
    chk("vec_rdata", rd_of(v.m), v.exp_rdata);
    $display("vec m%0d we=%0d addr=%h lat=%0d strobes=%0d err=%0d rdata=%h",
             v.m, v.we, v.addr, cyc, strobes, m0_err | m1_err, rd_of(v.m));
    req[v.m] = 1'b0; bus_ready = 1'b0;
    step();
  endtask

  initial begin
    int          last_m;
    logic [31:0] rd_m [2];
    int          w, k;
    bit          done, tmo;

    vecs[0] = '{0, 1'b0, 32'h80, 32'h0,        32'hDEADBEEF, 0,  1, 1'b0, 32'hDEADBEEF, 2};
    vecs[1] = '{1, 1'b1, 32'h84, 32'h12345678, 32'h0,        2,  3, 1'b0, 32'h0,        4};
    vecs[2] = '{0, 1'b0, 32'hF00, 32'h0,       32'h0,        99, 4, 1'b1, 32'hFFFFFFFF, 5};
    vecs[3] = '{0, 1'b0, 32'h10, 32'h0,        32'h00005A5A, 0,  1, 1'b0, 32'h00005A5A, 2};
    vecs[4] = '{1, 1'b0, 32'h20, 32'h0,        32'hCAFE0001, 3,  4, 1'b0, 32'hCAFE0001, 5};
    vecs[5] = '{1, 1'b1, 32'h24, 32'h55AA55AA, 32'h0,        99, 4, 1'b1, 32'hCAFE0001, 5};

    // Reset state
    do_reset();
    chk("rst_bus_read", bus_read, 1'b0);
    chk("rst_bus_write", bus_write, 1'b0);
    chk("rst_bus_addr", bus_addr, 32'h0);
    chk("rst_bus_wdata", bus_wdata, 32'h0);
    chk("rst_acks", {m1_ack, m0_ack, m1_err, m0_err}, 4'h0);
    chk("rst_m0_rdata", m0_rdata, 32'h0);
    chk("rst_m1_rdata", m1_rdata, 32'h0);

    // Directed single-master transactions
    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Contention from reset: continuous requests from both masters, slot always ready
    do_reset();
    req = 2'b11; we = 2'b00; addr[0] = 32'h1000; addr[1] = 32'h2000;
    bus_ready = 1'b1; bus_rdata = 32'h600DF00D;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      step();
      chk("cont_strobe", bus_read, (cyc % 3) == 1);
      if ((cyc % 3) == 1) chk("cont_addr", bus_addr, addr[(cyc / 3) % 2]);
      chk("cont_ack", {m1_ack, m0_ack}, ((cyc % 3) == 2) ? onehot((cyc / 3) % 2) : 2'b00);
      if (m0_ack || m1_ack) $display("contention ack m%0d at cycle %0d", m1_ack ? 1 : 0, cyc);
      if (cyc == 12) req = 2'b00;
    end
    bus_ready = 1'b0;
    step();

    // Reset in the 2nd ACCESS cycle of a master-0 read (master 0 went last)
    req[0] = 1'b1; we[0] = 1'b0; addr[0] = 32'h300;
    step();
    step();
    chk("rma_strobe_before", bus_read, 1'b1);
    rst = 1'b1;
    step();
    chk("rma_strobes", {bus_read, bus_write}, 2'b00);
    chk("rma_acks", {m1_ack, m0_ack}, 2'b00);
    chk("rma_m0_rdata", m0_rdata, 32'h0);
    chk("rma_m1_rdata", m1_rdata, 32'h0);
    chk("rma_bus_addr", bus_addr, 32'h0);
    rst = 1'b0; req = 2'b11; we = 2'b00; addr[0] = 32'h100; addr[1] = 32'h200;
    step();
    chk("rma_tie_m0", bus_addr, 32'h100);
    bus_ready = 1'b1; bus_rdata = 32'h77;
    step();
    chk("rma_m0_ack", {m1_ack, m0_ack}, 2'b01);
    chk("rma_m0_rdata2", m0_rdata, 32'h77);
    req[0] = 1'b0; bus_ready = 1'b0;
    step();
    step();
    chk("rma_m1_addr", bus_addr, 32'h200);
    bus_ready = 1'b1; bus_rdata = 32'h88;
    step();
    chk("rma_m1_ack", {m1_ack, m0_ack}, 2'b10);
    req = 2'b00; bus_ready = 1'b0;
    step();

    // Randomized traffic against a transaction-level reference
    do_reset();
    last_m = 1; rd_m[0] = '0; rd_m[1] = '0;
    for (int t = 0; t < 200; t++) begin
      for (int m = 0; m < 2; m++) begin
        if (!req[m] && $urandom_range(0, 2) != 0) begin
          req[m] = 1'b1; we[m] = 1'($urandom_range(0, 1));
          addr[m] = $urandom; wdata[m] = $urandom;
        end
      end
      bus_ready = 1'($urandom_range(0, 1)); bus_rdata = $urandom;
      chk("rnd_idle_strobes", {bus_read, bus_write}, 2'b00);
      chk("rnd_idle_acks", {m1_ack, m0_ack}, 2'b00);
      chk("rnd_idle_rd0", m0_rdata, rd_m[0]);
      chk("rnd_idle_rd1", m1_rdata, rd_m[1]);
      if (req == 2'b00) begin
        step();
        continue;
      end
      w = (req == 2'b11) ? 1 - last_m : (req[0] ? 0 : 1);
      last_m = w;
      step();
      k = 0; done = 0; tmo = 0;
      while (!done) begin
        chk("rnd_read", bus_read, !we[w]);
        chk("rnd_write", bus_write, we[w]);
        chk("rnd_addr", bus_addr, addr[w]);
        chk("rnd_wdata", bus_wdata, we[w] ? wdata[w] : 32'h0);
        chk("rnd_acc_acks", {m1_ack, m0_ack}, 2'b00);
        bus_rdata = $urandom;
        bus_ready = ($urandom_range(0, 3) == 0);
        if (bus_ready) done = 1;
        else if (k == TO - 1) begin done = 1; tmo = 1; end
        if (done && !we[w]) rd_m[w] = tmo ? 32'hFFFFFFFF : bus_rdata;
        k++;
        step();
      end
      chk("rnd_ack", {m1_ack, m0_ack}, onehot(w));
      chk("rnd_err", {m1_err, m0_err}, tmo ? onehot(w) : 2'b00);
      chk("rnd_done_strobes", {bus_read, bus_write}, 2'b00);
      chk("rnd_done_addr", bus_addr, 32'h0);
      chk("rnd_done_wdata", bus_wdata, 32'h0);
      chk("rnd_rd0", m0_rdata, rd_m[0]);
      chk("rnd_rd1", m1_rdata, rd_m[1]);
      $display("txn %0d m%0d we=%0d addr=%h cycles=%0d err=%0d rdata=%h",
               t, w, we[w], addr[w], k, tmo, rd_m[w]);
      if ($urandom_range(0, 1) == 0) begin
        req[w] = 1'b0;
      end else begin
        we[w] = 1'($urandom_range(0, 1)); addr[w] = $urandom; wdata[w] = $urandom;
      end
      bus_ready = 1'($urandom_range(0, 1));
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
